// File: rtl/vector_mult_stage_if.sv
// rtl/vector_mult_stage_if.sv - operand-in / product-out handshake bundle for vector_mult_stage
interface vector_mult_stage_if #(
  parameter int DIM = 4,
  parameter int W_a = 8,
  parameter int W_b = 8
);
  logic [DIM*W_a-1:0]       a;
  logic [DIM*W_b-1:0]       b;
  logic                     inValid;
  logic                     inReady;
  logic [DIM*(W_a+W_b)-1:0] u;
  logic                     outValid;
  logic                     outReady;

  modport master (output a, b, inValid, outReady, input inReady, u, outValid);
  modport slave  (input a, b, inValid, outReady, output inReady, u, outValid);
endinterface

// File: rtl/vector_mult_stage.sv
// rtl/vector_mult_stage.sv - elementwise multiply feeding vectorSum, LANES shared multipliers over DIM/LANES passes
module vector_mult_stage #(
  parameter int DIM   = 4,
  parameter int W_a   = 8,
  parameter int W_b   = 8,
  parameter int LANES = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  vector_mult_stage_if.slave link
);
  localparam int W_p    = W_a + W_b;
  localparam int PASSES = DIM / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  generate
    if (DIM % LANES != 0) begin : g_bad_lanes
      $error("vector_mult_stage: DIM must be a multiple of LANES");
    end
  endgenerate

  logic [1:0]         state_q;
  logic [PW-1:0]      pass_q;
  logic [DIM*W_a-1:0] a_q;
  logic [DIM*W_b-1:0] b_q;
  logic [DIM*W_p-1:0] u_q;
  logic [W_p-1:0]     prod [LANES];
  int                 lane_base;
  logic               last_pass;

  // The LANES multipliers only ever see the captured operands, never the live inputs.
  always_comb begin
    lane_base = int'(pass_q) * LANES;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = W_p'(a_q[(lane_base + l)*W_a +: W_a]) * W_p'(b_q[(lane_base + l)*W_b +: W_b]);
    end
  end

  assign last_pass = (pass_q == PW'(PASSES - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      u_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (link.inValid) begin
            a_q     <= link.a;
            b_q     <= link.b;
            pass_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            u_q[(lane_base + l)*W_p +: W_p] <= prod[l];
          end
          if (last_pass) begin
            pass_q  <= '0;
            state_q <= HOLD;
          end else begin
            pass_q  <= pass_q + PW'(1);
          end
        end
        HOLD: begin
          if (link.outReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only; reset gates inReady while asserted.
  assign link.inReady  = Reset_n && (state_q == IDLE);
  assign link.outValid = (state_q == HOLD);
  assign link.u        = u_q;
endmodule

// File: tb/tb_vector_mult_stage.sv
// tb/tb_vector_mult_stage.sv - directed self-checking bench for vector_mult_stage
module tb_vector_mult_stage;
  logic Clock = 1'b0;
  logic Reset_n;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  vector_mult_stage_if #(.DIM(4), .W_a(8), .W_b(8)) m_if ();
  vector_mult_stage_if #(.DIM(4), .W_a(8), .W_b(8)) s1_if ();
  vector_mult_stage_if #(.DIM(4), .W_a(8), .W_b(8)) s4_if ();

  vector_mult_stage #(.DIM(4), .W_a(8), .W_b(8), .LANES(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .link(m_if.slave));
  vector_mult_stage #(.DIM(4), .W_a(8), .W_b(8), .LANES(1)) dut_l1 (
    .Clock(Clock), .Reset_n(Reset_n), .link(s1_if.slave));
  vector_mult_stage #(.DIM(4), .W_a(8), .W_b(8), .LANES(4)) dut_l4 (
    .Clock(Clock), .Reset_n(Reset_n), .link(s4_if.slave));

  logic [31:0] sw_a, sw_b;
  logic        sw_inValid, sw_outReady;
  assign s1_if.a = sw_a;  assign s1_if.b = sw_b;
  assign s1_if.inValid = sw_inValid;  assign s1_if.outReady = sw_outReady;
  assign s4_if.a = sw_a;  assign s4_if.b = sw_b;
  assign s4_if.inValid = sw_inValid;  assign s4_if.outReady = sw_outReady;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_if.a = {$urandom, $urandom};
      m_if.b = {$urandom, $urandom};
      m_if.inValid  = 1'($urandom_range(0, 1));
      m_if.outReady = 1'($urandom_range(0, 1));
      sw_a = $urandom;
      sw_b = $urandom;
      step();
      n_checks++;
      if (m_if.u !== 64'h0) begin
        n_fail++; $display("FAIL reset_u: got %h expected %h", m_if.u, 64'h0);
      end
      n_checks++;
      if (m_if.outValid !== 1'b0) begin
        n_fail++; $display("FAIL reset_outValid: got %b expected 0", m_if.outValid);
      end
      n_checks++;
      if (m_if.inReady !== 1'b0) begin
        n_fail++; $display("FAIL reset_inReady: got %b expected 0", m_if.inReady);
      end
    end
    m_if.inValid  = 1'b0;
    m_if.outReady = 1'b0;
    #1 Reset_n = 1'b1;
    #1;
    n_checks++;
    if (m_if.inReady !== 1'b1) begin
      n_fail++; $display("FAIL release_inReady: got %b expected 1", m_if.inReady);
    end
    n_checks++;
    if (s1_if.inReady !== 1'b1 || s4_if.inReady !== 1'b1) begin
      n_fail++; $display("FAIL release_inReady_sweep: got %b%b expected 11", s1_if.inReady, s4_if.inReady);
    end
  endtask

  task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_u);
    n_checks++;
    if (m_if.inReady !== 1'b1) begin
      n_fail++; $display("FAIL %s_idle_inReady: got %b expected 1", name, m_if.inReady);
    end
    m_if.a = a;  m_if.b = b;
    m_if.inValid = 1'b1;  m_if.outReady = 1'b1;
    step();
    m_if.inValid = 1'b0;
    n_checks++;
    if (m_if.inReady !== 1'b0 || m_if.outValid !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy0: got inReady=%b outValid=%b expected 0 0", name, m_if.inReady, m_if.outValid);
    end
    step();
    n_checks++;
    if (m_if.outValid !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy1_outValid: got %b expected 0", name, m_if.outValid);
    end
    step();
    n_checks++;
    if (m_if.outValid !== 1'b1) begin
      n_fail++; $display("FAIL %s_latency_outValid: got %b expected 1", name, m_if.outValid);
    end
    n_checks++;
    if (m_if.u !== exp_u) begin
      n_fail++; $display("FAIL %s_u: got %h expected %h", name, m_if.u, exp_u);
    end
    step();
    n_checks++;
    if (m_if.outValid !== 1'b0 || m_if.inReady !== 1'b1) begin
      n_fail++; $display("FAIL %s_return_idle: got outValid=%b inReady=%b expected 0 1", name, m_if.outValid, m_if.inReady);
    end
  endtask

  task automatic test_basic();
    test_vector("basic", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 64'h0020_0015_000C_0005);
  endtask

  task automatic test_width();
    test_vector("width", 32'hFFFF_FFFF, 32'hFFFF_FFFF, {4{16'hFE01}});
  endtask

  task automatic test_backpressure();
    m_if.a = {4{8'd2}};  m_if.b = {4{8'd3}};
    m_if.inValid = 1'b1;  m_if.outReady = 1'b0;
    step();
    m_if.a = '0;  m_if.b = '0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (m_if.outValid !== 1'b1 || m_if.inReady !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d: got outValid=%b inReady=%b expected 1 0", i, m_if.outValid, m_if.inReady);
      end
      n_checks++;
      if (m_if.u !== {4{16'h0006}}) begin
        n_fail++; $display("FAIL bp_u_%0d: got %h expected %h", i, m_if.u, {4{16'h0006}});
      end
      step();
    end
    m_if.outReady = 1'b1;
    step();
    n_checks++;
    if (m_if.outValid !== 1'b0 || m_if.inReady !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got outValid=%b inReady=%b expected 0 1", m_if.outValid, m_if.inReady);
    end
    step();
    m_if.inValid = 1'b0;
    n_checks++;
    if (m_if.inReady !== 1'b0) begin
      n_fail++; $display("FAIL bp_pending_accept: got inReady=%b expected 0", m_if.inReady);
    end
    step();
    step();
    n_checks++;
    if (m_if.outValid !== 1'b1 || m_if.u !== 64'h0) begin
      n_fail++; $display("FAIL bp_second_u: got outValid=%b u=%h expected 1 %h", m_if.outValid, m_if.u, 64'h0);
    end
    step();
  endtask

  task automatic test_reset_midop();
    m_if.a = {8'd4, 8'd3, 8'd2, 8'd1};  m_if.b = {8'd8, 8'd7, 8'd6, 8'd5};
    m_if.inValid = 1'b1;  m_if.outReady = 1'b1;
    step();
    m_if.inValid = 1'b0;
    @(posedge Clock);
    #4 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (m_if.outValid !== 1'b0 || m_if.inReady !== 1'b0 || m_if.u !== 64'h0) begin
      n_fail++; $display("FAIL midop_reset: got outValid=%b inReady=%b u=%h expected 0 0 %h",
                         m_if.outValid, m_if.inReady, m_if.u, 64'h0);
    end
    step();
    Reset_n = 1'b1;
    #1;
    test_vector("after_reset", {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 64'h00A0_005A_0028_000A);
  endtask

  task automatic test_back_to_back();
    int r1[2] = '{-1, -1};
    int r4[2] = '{-1, -1};
    int n1 = 0, n4 = 0;
    logic p1 = 1'b0, p4 = 1'b0;
    logic [63:0] exp_u = 64'h0004_0006_0006_0004;
    sw_a = {8'd4, 8'd3, 8'd2, 8'd1};
    sw_b = {8'd1, 8'd2, 8'd3, 8'd4};
    sw_inValid = 1'b1;  sw_outReady = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_checks++;
      if ((s1_if.outValid && s1_if.inReady) || (s4_if.outValid && s4_if.inReady)) begin
        n_fail++; $display("FAIL sweep_inReady_in_hold_%0d: got L1=%b L4=%b expected 0 0", k,
                           s1_if.inReady && s1_if.outValid, s4_if.inReady && s4_if.outValid);
      end
      if (s1_if.outValid && !p1) begin
        if (n1 < 2) r1[n1] = k;
        n1++;
        n_checks++;
        if (s1_if.u !== exp_u) begin
          n_fail++; $display("FAIL sweep_l1_u: got %h expected %h", s1_if.u, exp_u);
        end
      end
      if (s4_if.outValid && !p4) begin
        if (n4 < 2) r4[n4] = k;
        n4++;
        n_checks++;
        if (s4_if.u !== exp_u) begin
          n_fail++; $display("FAIL sweep_l4_u: got %h expected %h", s4_if.u, exp_u);
        end
      end
      p1 = s1_if.outValid;
      p4 = s4_if.outValid;
    end
    sw_inValid = 1'b0;
    n_checks++;
    if (r1[0] != 5) begin
      n_fail++; $display("FAIL sweep_l1_latency: got edge %0d expected edge 5", r1[0]);
    end
    n_checks++;
    if (n1 < 2 || r1[1] - r1[0] != 6) begin
      n_fail++; $display("FAIL sweep_l1_interval: got %0d expected 6", (n1 < 2) ? -1 : r1[1] - r1[0]);
    end
    n_checks++;
    if (r4[0] != 2) begin
      n_fail++; $display("FAIL sweep_l4_latency: got edge %0d expected edge 2", r4[0]);
    end
    n_checks++;
    if (n4 < 2 || r4[1] - r4[0] != 3) begin
      n_fail++; $display("FAIL sweep_l4_interval: got %0d expected 3", (n4 < 2) ? -1 : r4[1] - r4[0]);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    m_if.a = '0;  m_if.b = '0;
    m_if.inValid = 1'b0;  m_if.outReady = 1'b0;
    sw_a = '0;  sw_b = '0;
    sw_inValid = 1'b0;  sw_outReady = 1'b0;
    test_reset();
    step();
    test_basic();
    test_width();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
